// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: SIO register-select codes, SIOC default and scheduler states.
// Revision: 1.0
`default_nettype none

package jtdsp16_pkg;

  localparam logic [2:0]  RF_SIOC       = 3'd0;
  localparam logic [2:0]  RF_SRTA       = 3'd1;
  localparam logic [2:0]  RF_SDX        = 3'd2;
  localparam logic [15:0] SIOC_INIT_DEF = 16'h02E8;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_SRTA = 3'd2,
    ST_SDX  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/jtdsp16_fifo.sv
// jtdsp16_fifo: synchronous FIFO with occupancy output; full/empty told apart by level.
// Revision: 1.0
`default_nettype none

module jtdsp16_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             w_push, w_pop;

  assign w_push  = push_i && (level_q != FULL_LVL);
  assign w_pop   = pop_i && (level_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth makes the natural pointer overflow the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jtdsp16_sio_sched.sv
// jtdsp16_sio_sched: queues {addr,data} words and feeds them to the DSP16 SIO
// as SIOC/SRTA/SDX immediate loads, skipping SRTA when the address repeats.
`default_nettype none

module jtdsp16_sio_sched
  import jtdsp16_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] SIOC_INIT = SIOC_INIT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ph1,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [7:0]             req_addr,
  input  logic [15:0]            req_data,
  input  logic                   obe,
  output logic                   sio_load,
  output logic [2:0]             r_field,
  output logic [15:0]            load_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  state_t      state_q, state_d;
  logic [7:0]  last_addr_q, last_addr_d;
  logic        addr_valid_q, addr_valid_d;
  logic        w_pop;
  logic [23:0] w_head;
  logic [7:0]  w_head_addr;
  logic [15:0] w_head_data;

  assign req_ready   = (level != FULL_LVL);
  assign busy        = (state_q != ST_IDLE) || (level != '0);
  assign w_head_addr = w_head[23:16];
  assign w_head_data = w_head[15:0];

  jtdsp16_fifo #(
    .WIDTH (24),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && req_ready),
    .pop_i   (w_pop),
    .wdata_i ({req_addr, req_data}),
    .rdata_o (w_head),
    .level_o (level)
  );

  always_comb begin
    state_d      = state_q;
    last_addr_d  = last_addr_q;
    addr_valid_d = addr_valid_q;
    sio_load     = 1'b0;
    r_field      = RF_SIOC;
    load_data    = '0;
    w_pop        = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (ph1) begin
          sio_load  = 1'b1;
          load_data = SIOC_INIT;
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ph1 && obe && (level != '0))
          state_d = (!addr_valid_q || (w_head_addr != last_addr_q)) ? ST_SRTA : ST_SDX;
      end
      // Loads stall while obe is low so the SIO buffer is never overwritten.
      ST_SRTA: begin
        if (ph1 && obe) begin
          sio_load     = 1'b1;
          r_field      = RF_SRTA;
          load_data    = {8'h00, w_head_addr};
          last_addr_d  = w_head_addr;
          addr_valid_d = 1'b1;
          state_d      = ST_SDX;
        end
      end
      ST_SDX: begin
        if (ph1 && obe) begin
          sio_load  = 1'b1;
          r_field   = RF_SDX;
          load_data = w_head_data;
          w_pop     = 1'b1;
          state_d   = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ph1) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      last_addr_q  <= 8'h00;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_addr_q  <= last_addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtdsp16_sio_sched.sv
// tb_jtdsp16_sio_sched: directed self-checking bench, ph1 high every second clk.
`default_nettype none

module tb_jtdsp16_sio_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, ph1, req_valid, obe;
  logic        req_ready, sio_load, busy;
  logic [7:0]  req_addr;
  logic [15:0] req_data, load_data;
  logic [2:0]  r_field;
  logic [2:0]  level;

  int n_cmp = 0;
  int n_err = 0;

  logic        s_load;
  logic [2:0]  s_rf;
  logic [15:0] s_data;

  jtdsp16_sio_sched #(.DEPTH(DEPTH), .SIOC_INIT(16'h02E8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ph1       (ph1),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .obe       (obe),
    .sio_load  (sio_load),
    .r_field   (r_field),
    .load_data (load_data),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // One ph1 cycle: capture outputs while ph1=1, then confirm silence while ph1=0.
  task automatic ph_cycle();
    ph1 = 1'b1;
    #1;
    s_load = sio_load;
    s_rf   = r_field;
    s_data = load_data;
    adv();
    req_valid = 1'b0;
    ph1 = 1'b0;
    #1;
    chk("no_load_ph1_low", {31'd0, sio_load}, 32'd0);
    adv();
  endtask

  task automatic expect_load(input string tag, input logic [2:0] rf, input logic [15:0] d);
    chk({tag, "_load"}, {31'd0, s_load}, 32'd1);
    chk({tag, "_rf"},   {29'd0, s_rf},   {29'd0, rf});
    chk({tag, "_data"}, {16'd0, s_data}, {16'd0, d});
  endtask

  task automatic expect_none(input string tag);
    chk({tag, "_noload"}, {31'd0, s_load}, 32'd0);
    chk({tag, "_rf0"},    {13'd0, s_rf, s_data}, 32'd0);
  endtask

  task automatic push(input logic [7:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    ph1       = 1'b0;
    adv();
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ph1 = 1'b0; req_valid = 1'b0; obe = 1'b0;
    req_addr = 8'h00; req_data = 16'h0000;
    s_load = 1'b0; s_rf = 3'd0; s_data = 16'h0;
    adv(); adv();
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_load",   {31'd0, sio_load},  32'd0);
    chk("rst_rfield", {29'd0, r_field},   32'd0);
    chk("rst_data",   {16'd0, load_data}, 32'd0);
    chk("rst_busy",   {31'd0, busy},      32'd1);
    chk("rst_level",  {29'd0, level},     32'd0);
    rst = 1'b0;
    adv();

    // INIT load on first ph1
    ph_cycle();
    expect_load("init", 3'd0, 16'h02E8);
    chk("init_busy", {31'd0, busy}, 32'd0);

    // New address: SRTA then SDX on consecutive ph1 cycles
    obe = 1'b1;
    push(8'h80, 16'h1234);
    chk("push1_level", {29'd0, level}, 32'd1);
    ph_cycle(); expect_none("a_idle");
    ph_cycle(); expect_load("a_srta", 3'd1, 16'h0080);
    ph_cycle(); expect_load("a_sdx",  3'd2, 16'h1234);
    obe = 1'b0;
    ph_cycle(); expect_none("a_hold");
    chk("a_level", {29'd0, level}, 32'd0);

    // Same address: no SRTA, SDX waits for obe
    push(8'h80, 16'h5678);
    ph_cycle(); expect_none("b_wait0");
    ph_cycle(); expect_none("b_wait1");
    chk("b_busy", {31'd0, busy}, 32'd1);
    obe = 1'b1;
    ph_cycle(); expect_none("b_idle");
    ph_cycle(); expect_load("b_sdx", 3'd2, 16'h5678);
    obe = 1'b0;
    ph_cycle(); expect_none("b_hold");

    // Fill beyond DEPTH with obe low
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) chk("full_ready", {31'd0, req_ready}, 32'd0);
      else            chk("fill_ready", {31'd0, req_ready}, 32'd1);
      push(8'h90, 16'hA000 + 16'(i));
    end
    chk("full_level", {29'd0, level}, 32'd4);
    ph_cycle(); expect_none("full_obe0_a");
    ph_cycle(); expect_none("full_obe0_b");

    // Drain to DEPTH-1, then push while popping
    obe = 1'b1;
    ph_cycle(); expect_none("c_idle");
    ph_cycle(); expect_load("c_srta", 3'd1, 16'h0090);
    ph_cycle(); expect_load("c_sdx0", 3'd2, 16'hA000);
    chk("c_level3", {29'd0, level}, 32'd3);
    ph_cycle(); expect_none("c_hold");
    ph_cycle(); expect_none("c_idle2");
    req_valid = 1'b1; req_addr = 8'h90; req_data = 16'hB000;
    ph_cycle(); expect_load("c_sdx1", 3'd2, 16'hA001);
    chk("c_pushpop_level", {29'd0, level}, 32'd3);
    ph_cycle(); expect_none("c_hold1");
    ph_cycle(); expect_none("c_idle3");
    ph_cycle(); expect_load("c_sdx2", 3'd2, 16'hA002);
    ph_cycle(); ph_cycle();
    ph_cycle(); expect_load("c_sdx3", 3'd2, 16'hA003);
    ph_cycle(); ph_cycle();
    ph_cycle(); expect_load("c_sdx4", 3'd2, 16'hB000);
    ph_cycle();
    chk("c_empty", {29'd0, level}, 32'd0);

    // Reset between SRTA and SDX
    push(8'h40, 16'hC0DE);
    ph_cycle(); expect_none("d_idle");
    ph_cycle(); expect_load("d_srta", 3'd1, 16'h0040);
    rst = 1'b1;
    #1;
    chk("d_rst_level", {29'd0, level},    32'd0);
    chk("d_rst_load",  {31'd0, sio_load}, 32'd0);
    chk("d_rst_busy",  {31'd0, busy},     32'd1);
    adv();
    rst = 1'b0;
    adv();
    ph_cycle(); expect_load("d_init", 3'd0, 16'h02E8);
    ph_cycle(); expect_none("d_after");
    chk("d_level", {29'd0, level}, 32'd0);
    chk("d_busy",  {31'd0, busy},  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
